// File: rtl/al422_bam_pkg.sv
// Shared types and helpers for the AL422-fed HUB75 BAM scan engine.
package al422_bam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RELEASE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY,
    ST_BLANK,
    ST_FRAME_END
  } scan_state_e;

  localparam int RGB_W    = 3;
  localparam int RGB1_LSB = 0;
  localparam int RGB2_LSB = 3;

  // Wide enough for the largest plane weight times the full brightness range.
  function automatic int on_time_width(input int base_cycles, input int planes);
    int max_v;
    max_v = base_cycles * (1 << (planes - 1)) * 256 + 1;
    return $clog2(max_v);
  endfunction

endpackage

// File: rtl/al422_bam_scan_on_timer.sv
// BAM on-time loader and down-counter for one bit plane.
// Brightness scaling is compiled in only when BAM_BRIGHTNESS_EN is defined.
module bam_on_timer
  import al422_bam_pkg::*;
#(
  parameter int BASE_CYCLES = 4,
  parameter int PLANE_W     = 3,
  parameter int OTW         = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [PLANE_W-1:0] plane,
  input  logic [7:0]         brightness,
  output logic               zero,
  output logic               done
);

  logic [OTW-1:0] base_shift;
  logic [OTW-1:0] on_time;
  logic [OTW-1:0] cnt_d;
  logic [OTW-1:0] cnt_q;

  always_comb base_shift = OTW'(BASE_CYCLES) << plane;

`ifdef BAM_BRIGHTNESS_EN
  logic [OTW-1:0] scale;
  logic [OTW-1:0] product;

  // Full-width product before the shift so small planes keep their fraction.
  always_comb begin
    scale   = OTW'({1'b0, brightness}) + OTW'(1);
    product = base_shift * scale;
    on_time = product >> 8;
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  always_comb on_time = base_shift;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = on_time;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (on_time == '0);
  assign done = (cnt_q <= OTW'(1));

endmodule

// File: rtl/al422_bam_scan.sv
// HUB75 bit-angle-modulation scan engine reading pre-sliced planes from an AL422 FIFO.
// Optional global brightness scaling is enabled with BAM_BRIGHTNESS_EN.
module al422_bam_scan
  import al422_bam_pkg::*;
#(
  parameter int COLS        = 64,
  parameter int PLANES      = 8,
  parameter int ROW_BITS    = 5,
  parameter int BASE_CYCLES = 4
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                start,
  input  logic [7:0]          brightness,
  input  logic [7:0]          in_data,
  output logic                al422_re_out,
  output logic                al422_nrst_out,
  output logic                led_clk_out,
  output logic                led_lat_out,
  output logic                led_oe_out,
  output logic [ROW_BITS-1:0] led_row,
  output logic [2:0]          rgb1,
  output logic [2:0]          rgb2,
  output logic                frame_done
);

  localparam int OTW     = on_time_width(BASE_CYCLES, PLANES);
  localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam int C_W     = $clog2(2 * COLS + 1);

  localparam logic [C_W-1:0]      C_LAST     = C_W'(2 * COLS);
  localparam logic [C_W-1:0]      C_TWO      = C_W'(2);
  localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(PLANES - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;

  scan_state_e         state_d, state_q;
  logic [C_W-1:0]      col_d, col_q;
  logic [PLANE_W-1:0]  plane_d, plane_q;
  logic [ROW_BITS-1:0] row_d, row_q;
  logic                tmr_load, tmr_dec, tmr_zero, tmr_done;

  logic                re_d, re_q;
  logic                nrst_d, nrst_q;
  logic                lclk_d, lclk_q;
  logic                lat_d, lat_q;
  logic                oe_d, oe_q;
  logic                done_d, done_q;
  logic [ROW_BITS-1:0] led_row_d, led_row_q;
  logic [2:0]          rgb1_d, rgb1_q;
  logic [2:0]          rgb2_d, rgb2_q;

  logic unused_in_bits;
  assign unused_in_bits = ^in_data[7:6];

  bam_on_timer #(
    .BASE_CYCLES(BASE_CYCLES),
    .PLANE_W    (PLANE_W),
    .OTW        (OTW)
  ) u_on_timer (
    .clk       (in_clk),
    .rst       (in_rst),
    .load      (tmr_load),
    .dec       (tmr_dec),
    .plane     (plane_q),
    .brightness(brightness),
    .zero      (tmr_zero),
    .done      (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    plane_d  = plane_q;
    row_d    = row_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        col_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (col_q == C_LAST) begin
          col_d   = '0;
          state_d = ST_LATCH;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_LATCH: begin
        tmr_load = 1'b1;
        state_d  = tmr_zero ? ST_BLANK : ST_DISPLAY;
      end
      ST_DISPLAY: begin
        tmr_dec = 1'b1;
        if (tmr_done) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (plane_q == PLANE_LAST) begin
          plane_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = ST_FRAME_END;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_SHIFT;
          end
        end else begin
          plane_d = plane_q + 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_FRAME_END: begin
        row_d   = '0;
        plane_d = '0;
        state_d = start ? ST_RELEASE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so every
  // pin trails its state by one cycle; rgb captures on the edge closing a read.
  always_comb begin
    re_d      = 1'b1;
    nrst_d    = 1'b1;
    lclk_d    = 1'b0;
    lat_d     = 1'b0;
    oe_d      = 1'b1;
    done_d    = 1'b0;
    led_row_d = led_row_q;
    rgb1_d    = re_q ? rgb1_q : in_data[RGB1_LSB +: RGB_W];
    rgb2_d    = re_q ? rgb2_q : in_data[RGB2_LSB +: RGB_W];
    case (state_q)
      ST_IDLE: nrst_d = 1'b0;
      ST_SHIFT: begin
        re_d   = ~(~col_q[0] && (col_q < C_LAST));
        lclk_d = ~col_q[0] && (col_q >= C_TWO);
      end
      ST_LATCH: begin
        lat_d     = 1'b1;
        led_row_d = row_q;
      end
      ST_DISPLAY: oe_d = 1'b0;
      ST_FRAME_END: begin
        nrst_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      plane_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      plane_q <= plane_d;
      row_q   <= row_d;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      re_q      <= 1'b1;
      nrst_q    <= 1'b0;
      lclk_q    <= 1'b0;
      lat_q     <= 1'b0;
      oe_q      <= 1'b1;
      done_q    <= 1'b0;
      led_row_q <= '0;
      rgb1_q    <= '0;
      rgb2_q    <= '0;
    end else begin
      re_q      <= re_d;
      nrst_q    <= nrst_d;
      lclk_q    <= lclk_d;
      lat_q     <= lat_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      led_row_q <= led_row_d;
      rgb1_q    <= rgb1_d;
      rgb2_q    <= rgb2_d;
    end
  end

  assign al422_re_out   = re_q;
  assign al422_nrst_out = nrst_q;
  assign led_clk_out    = lclk_q;
  assign led_lat_out    = lat_q;
  assign led_oe_out     = oe_q;
  assign led_row        = led_row_q;
  assign rgb1           = rgb1_q;
  assign rgb2           = rgb2_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_al422_bam_scan.sv
// Randomised frame-level bench for al422_bam_scan with an AL422 read-side model.
module tb_al422_bam_scan;

  localparam int COLS   = 4;
  localparam int PLANES = 2;
  localparam int RBITS  = 1;
  localparam int BASE   = 4;
  localparam int ROWS   = 1 << RBITS;
  localparam int FRAME  = ROWS * PLANES * COLS;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       brightness;
  logic [7:0]       in_data;
  logic             al422_re_out, al422_nrst_out;
  logic             led_clk_out, led_lat_out, led_oe_out;
  logic [RBITS-1:0] led_row;
  logic [2:0]       rgb1, rgb2;
  logic             frame_done;

  logic [7:0]  mem [0:2*FRAME-1];
  int unsigned rd_ptr = 0;
  int          n_chk  = 0;
  int          n_pass = 0;

  al422_bam_scan #(
    .COLS(COLS), .PLANES(PLANES), .ROW_BITS(RBITS), .BASE_CYCLES(BASE)
  ) dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .start         (start),
    .brightness    (brightness),
    .in_data       (in_data),
    .al422_re_out  (al422_re_out),
    .al422_nrst_out(al422_nrst_out),
    .led_clk_out   (led_clk_out),
    .led_lat_out   (led_lat_out),
    .led_oe_out    (led_oe_out),
    .led_row       (led_row),
    .rgb1          (rgb1),
    .rgb2          (rgb2),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  // AL422 read side: data for the current pointer, advance per read, reset on nrst low.
  assign in_data = mem[rd_ptr % (2 * FRAME)];
  always @(posedge clk) begin
    if (!al422_nrst_out) rd_ptr <= 0;
    else if (!al422_re_out) rd_ptr <= rd_ptr + 1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int exp_on(input int p, input int b);
`ifdef BAM_BRIGHTNESS_EN
    return ((BASE << p) * (b + 1)) / 256;
`else
    return BASE << p;
`endif
  endfunction

  function automatic int exp_period(input int b);
    int s;
    s = 0;
    for (int p = 0; p < PLANES; p++) s += 2 * COLS + 1 + 1 + exp_on(p, b) + 1;
    return 2 + ROWS * s;
  endfunction

  task automatic run_frame(input int b, input bit cont, input bit stop_mid);
    int  cyc, reads, rises, lats, oe_cnt;
    bit  got_done;
    brightness = 8'(b);
    cyc = 0; reads = 0; rises = 0; lats = 0; oe_cnt = 0; got_done = 0;
    while (!got_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cont && cyc == 1) begin
        chk("done_width", frame_done, 0);
        chk("nrst_width", al422_nrst_out, 1);
      end
      if (!al422_re_out) reads++;
      if (!led_oe_out) oe_cnt++;
      if (led_clk_out) begin
        if (rises < FRAME) chk("rgb", {rgb2, rgb1}, mem[rises][5:0]);
        else chk("extra_clk", rises, FRAME - 1);
        rises++;
      end
      if (led_lat_out) begin
        if (lats > 0) chk("oe_len", oe_cnt, exp_on((lats - 1) % PLANES, b));
        chk("lat_after_cols", rises, (lats + 1) * COLS);
        chk("row_at_lat", led_row, lats / PLANES);
        chk("oe_at_lat", led_oe_out, 1);
        oe_cnt = 0;
        lats++;
        if (stop_mid && lats == 1) start = 1'b0;
      end
      if (frame_done) begin
        got_done = 1;
        chk("oe_len_last", oe_cnt, exp_on(PLANES - 1, b));
        chk("reads", reads, FRAME);
        chk("lats", lats, ROWS * PLANES);
        chk("nrst_at_done", al422_nrst_out, 0);
        if (cont) chk("period", cyc, exp_period(b));
      end
    end
    if (!got_done) chk("frame_timeout", got_done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, bad;
    int blist[6];
    for (int i = 0; i < FRAME; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h3F; mem[1] = 8'h00; mem[2] = 8'h3F; mem[3] = 8'h00;
    for (int i = 0; i < FRAME; i++) mem[FRAME + i] = mem[i] ^ 8'h3F;

    rst = 1'b1; start = 1'b0; brightness = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_re", al422_re_out, 1);
    chk("rst_nrst", al422_nrst_out, 0);
    chk("rst_lclk", led_clk_out, 0);
    chk("rst_lat", led_lat_out, 0);
    chk("rst_oe", led_oe_out, 1);
    chk("rst_row", led_row, 0);
    chk("rst_rgb", {rgb2, rgb1}, 0);
    chk("rst_done", frame_done, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_nrst", al422_nrst_out, 0);
    chk("idle_re", al422_re_out, 1);

    // start-to-FIFO timing, then async reset while OE is active
    start = 1'b1;
    @(posedge clk); #1 chk("nrst_edge1", al422_nrst_out, 0);
    @(posedge clk); #1 chk("nrst_edge2", al422_nrst_out, 1);
    chk("re_before_first", al422_re_out, 1);
    @(posedge clk); #1 chk("re_first", al422_re_out, 0);
    n = 0;
    while (led_oe_out && n < 500) begin @(negedge clk); n++; end
    chk("oe_seen_low", led_oe_out, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_oe", led_oe_out, 1);
    chk("arst_nrst", al422_nrst_out, 0);
    chk("arst_re", al422_re_out, 1);
    chk("arst_rgb", {rgb2, rgb1}, 0);
    chk("arst_row", led_row, 0);
    start = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);

    blist[0] = 255; blist[1] = 127; blist[2] = 0;
    for (int i = 3; i < 6; i++) blist[i] = int'($urandom_range(0, 255));
    start = 1'b1;
    for (int f = 0; f < 6; f++) run_frame(blist[f], f > 0, 1'b0);
    run_frame(int'($urandom_range(1, 255)), 1'b1, 1'b1);

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (al422_nrst_out || !al422_re_out || frame_done || !led_oe_out) bad++;
    end
    chk("stopped_idle", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
